// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath width, ALU op classes and the
// control-bit bundle that travels alongside every instruction from ID to EX.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  // ALU op classes as produced by the main decoder
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX transfer bundle: decoded ID fields in, registered IDEX fields out,
// plus the stall/flush controls and the load-use hazard flag.
interface id_ex_stage_if #(
  parameter int XLEN = rv32i_pkg::XLEN
);

  logic            stall;
  logic            flush;
  logic            load_use;

  logic            ID_valid;
  logic [XLEN-1:0] ID_pc;
  logic [XLEN-1:0] ID_rs1_data;
  logic [XLEN-1:0] ID_rs2_data;
  logic [XLEN-1:0] ID_imm;
  logic [4:0]      ID_rs1;
  logic [4:0]      ID_rs2;
  logic [4:0]      ID_rd;
  logic            ID_uses_rs1;
  logic            ID_uses_rs2;
  logic [2:0]      ID_funct3;
  logic            ID_funct7b5;
  logic            ID_reg_write;
  logic            ID_mem_read;
  logic            ID_mem_write;
  logic            ID_mem_to_reg;
  logic            ID_alu_src;
  logic            ID_branch;
  logic            ID_jump;
  logic [1:0]      ID_alu_op;

  logic            IDEX_valid;
  logic [XLEN-1:0] IDEX_pc;
  logic [XLEN-1:0] IDEX_rs1_data;
  logic [XLEN-1:0] IDEX_rs2_data;
  logic [XLEN-1:0] IDEX_imm;
  logic [4:0]      IDEX_rs1;
  logic [4:0]      IDEX_rs2;
  logic [4:0]      IDEX_rd;
  logic [2:0]      IDEX_funct3;
  logic            IDEX_funct7b5;
  logic            IDEX_reg_write;
  logic            IDEX_mem_read;
  logic            IDEX_mem_write;
  logic            IDEX_mem_to_reg;
  logic            IDEX_alu_src;
  logic            IDEX_branch;
  logic            IDEX_jump;
  logic [1:0]      IDEX_alu_op;

  modport master (
    output stall, flush,
    output ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
    output ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2,
    output ID_funct3, ID_funct7b5,
    output ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg,
    output ID_alu_src, ID_branch, ID_jump, ID_alu_op,
    input  load_use,
    input  IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
    input  IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_funct3, IDEX_funct7b5,
    input  IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg,
    input  IDEX_alu_src, IDEX_branch, IDEX_jump, IDEX_alu_op
  );

  modport slave (
    input  stall, flush,
    input  ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
    input  ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2,
    input  ID_funct3, ID_funct7b5,
    input  ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg,
    input  ID_alu_src, ID_branch, ID_jump, ID_alu_op,
    output load_use,
    output IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
    output IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_funct3, IDEX_funct7b5,
    output IDEX_reg_write, IDEX_mem_read, IDEX_mem_write, IDEX_mem_to_reg,
    output IDEX_alu_src, IDEX_branch, IDEX_jump, IDEX_alu_op
  );

endinterface

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter used for the pipeline debug event counts; it sticks
// at all-ones instead of wrapping so a long run never reads back as small.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         r,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (r) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, hold, squash and
// automatic bubble insertion, plus saturating bubble/flush debug counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             r,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  import rv32i_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    ctrl_t           ctrl;
  } ex_fields_t;

  ex_fields_t ex_q;
  ex_fields_t ex_d;
  ex_fields_t id_in;
  ex_fields_t bubble;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic load_use;
  logic flush_inc;
  logic bubble_inc;

  // A bubble zeroes every field, so downstream forwarding never matches rd
  always_comb begin
    bubble      = '0;
    bubble.ctrl = CTRL_BUBBLE;
  end

  always_comb begin
    id_in                 = '0;
    id_in.valid           = bus.ID_valid;
    id_in.pc              = bus.ID_pc;
    id_in.rs1_data        = bus.ID_rs1_data;
    id_in.rs2_data        = bus.ID_rs2_data;
    id_in.imm             = bus.ID_imm;
    id_in.rs1             = bus.ID_rs1;
    id_in.rs2             = bus.ID_rs2;
    id_in.rd              = bus.ID_rd;
    id_in.funct3          = bus.ID_funct3;
    id_in.funct7b5        = bus.ID_funct7b5;
    id_in.ctrl.reg_write  = bus.ID_reg_write;
    id_in.ctrl.mem_read   = bus.ID_mem_read;
    id_in.ctrl.mem_write  = bus.ID_mem_write;
    id_in.ctrl.mem_to_reg = bus.ID_mem_to_reg;
    id_in.ctrl.alu_src    = bus.ID_alu_src;
    id_in.ctrl.branch     = bus.ID_branch;
    id_in.ctrl.jump       = bus.ID_jump;
    id_in.ctrl.alu_op     = bus.ID_alu_op;
  end

  // A load in EX whose rd is read by the ID instruction cannot be forwarded yet
  assign rs1_hit  = bus.ID_uses_rs1 && (bus.ID_rs1 == ex_q.rd);
  assign rs2_hit  = bus.ID_uses_rs2 && (bus.ID_rs2 == ex_q.rd);
  assign hazard   = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != REG_X0) &&
                    (rs1_hit || rs2_hit) && bus.ID_valid;
  assign load_use = hazard && !bus.flush;

  assign bus.load_use = load_use;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = bubble;
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (load_use || !bus.ID_valid) begin
      ex_d = bubble;
    end else begin
      ex_d = id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Stall freezes the producer load as well, so no bubble is counted then
  assign flush_inc  = bus.flush;
  assign bubble_inc = load_use && !bus.stall;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .r     (r),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .r     (r),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign bus.IDEX_valid      = ex_q.valid;
  assign bus.IDEX_pc         = ex_q.pc;
  assign bus.IDEX_rs1_data   = ex_q.rs1_data;
  assign bus.IDEX_rs2_data   = ex_q.rs2_data;
  assign bus.IDEX_imm        = ex_q.imm;
  assign bus.IDEX_rs1        = ex_q.rs1;
  assign bus.IDEX_rs2        = ex_q.rs2;
  assign bus.IDEX_rd         = ex_q.rd;
  assign bus.IDEX_funct3     = ex_q.funct3;
  assign bus.IDEX_funct7b5   = ex_q.funct7b5;
  assign bus.IDEX_reg_write  = ex_q.ctrl.reg_write;
  assign bus.IDEX_mem_read   = ex_q.ctrl.mem_read;
  assign bus.IDEX_mem_write  = ex_q.ctrl.mem_write;
  assign bus.IDEX_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign bus.IDEX_alu_src    = ex_q.ctrl.alu_src;
  assign bus.IDEX_branch     = ex_q.ctrl.branch;
  assign bus.IDEX_jump       = ex_q.ctrl.jump;
  assign bus.IDEX_alu_op     = ex_q.ctrl.alu_op;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection. It captures decoded operands, register indices and control bits from ID. It presents the IDEX_* fields that the EX-stage forwarding logic and ALU consume. It also supports hold (stall), squash (flush) and automatic bubble insertion, and keeps saturating bubble/flush counters for debug.

Parameters:
XLEN, 32, datapath width (operands, PC, immediate)
CNT_W, 16, width of each saturating event counter

Ports:
clk  in  1  system clock, rising edge
r  in  1  reset, synchronous, active-high
stall  in  1  external hold (e.g. memory wait); freezes register contents
flush  in  1  squash ID->EX transfer (taken branch/jump resolved in EX)
ID_valid  in  1  ID holds a real instruction
ID_pc  in  XLEN  PC of ID instruction
ID_rs1_data, ID_rs2_data  in  XLEN  regfile read data
ID_imm  in  XLEN  sign-extended immediate
ID_rs1, ID_rs2, ID_rd  in  5  register indices
ID_uses_rs1, ID_uses_rs2  in  1  instruction actually reads rs1/rs2
ID_funct3  in  3  funct3
ID_funct7b5  in  1  instr bit 30
ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg, ID_alu_src, ID_branch, ID_jump  in  1 each  control bits
ID_alu_op  in  2  ALU op class
IDEX_*  out  same widths as ID_* counterparts (valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7b5, all control bits, alu_op)  registered EX-stage fields
load_use  out  1  combinational; upstream must hold PC and IF/ID this cycle
bubble_count  out  CNT_W  bubbles inserted by load_use
flush_count  out  CNT_W  flushes applied

Behaviour:
- Single clock clk. Reset r is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: every IDEX_* output = 0, including rs1/rs2/rd = 0, so forwarding sees no match. Both counters = 0. Reset mid-stall or mid-flush wins unconditionally.
- load_use is combinational:
  - load_use = IDEX_valid & IDEX_mem_read & (IDEX_rd != 0) & ((ID_uses_rs1 & ID_rs1 == IDEX_rd) | (ID_uses_rs2 & ID_rs2 == IDEX_rd)) & ID_valid.
  - It is forced to 0 while flush = 1.
- Per-edge priority when r = 0:
  1. flush = 1: load a bubble. Bubble = valid, all control bits, alu_op, rs1, rs2, rd = 0. Data fields pc, rs1_data, rs2_data, imm, funct3 and funct7b5 are don't-care and are driven to 0. flush_count increments.
  2. Else stall = 1: hold all IDEX_* fields unchanged. Counters unchanged. The load_use value is ignored for bubbling, because the producer load is held too.
  3. Else load_use = 1: load a bubble. bubble_count increments. The ID instruction is re-presented on the next cycle by upstream.
  4. Else: capture all ID_* fields into IDEX_*.
- An ID instruction with ID_valid = 0 is captured as a bubble: control bits and indices are zeroed regardless of the other inputs.
- Latency: one cycle from ID to IDEX in the capture case.
- A load-use stall lasts exactly one bubble. The next cycle the load sits in EX/MEM, and MEM/WB forwarding covers the dependency.
- Counters saturate at 2^CNT_W-1 and never wrap.
- rd = 0 loads never raise load_use.
- Loads with IDEX_valid = 0 (bubbles) never raise load_use.

Decomposition:
- Shared package rv32i_pkg holds:
  - ALU_OP_* encodings (2-bit);
  - the REG_X0 = 5'd0 constant;
  - a bubble-control constant giving the all-zero control vector;
  - XLEN.
- One natural sub-module: sat_counter (parameter W; inputs clk, r, inc; output count). Instantiate it twice.
- Hazard detection stays inline.

Test Plan:
- Reset: r = 1 for 2 cycles with random ID_* inputs -> all IDEX_* = 0, counters = 0, load_use = 0.
- Capture: ID_pc = 0x100, rs1 = 5, rs2 = 6, rd = 7, reg_write = 1, ID_valid = 1, stall = flush = 0 -> next cycle IDEX_pc = 0x100, IDEX_rd = 7, IDEX_reg_write = 1.
- Load-use:
  - Stimulus: lw x7 in IDEX (mem_read = 1, rd = 7, valid = 1) while ID = add using rs1 = 7 -> load_use = 1 that cycle; next edge gives a bubble (IDEX_valid = 0, reg_write = 0, rd = 0) and bubble_count = 1.
  - Variant: ID_rs1 = 7 but ID_uses_rs1 = 0 -> load_use = 0.
  - Variant: IDEX_rd = 0 -> load_use = 0.
- Stall vs flush: stall = 1 and flush = 1 together -> bubble loaded, flush_count = 1. Stall alone for 3 cycles -> IDEX fields unchanged, counters unchanged.
- Stall during load-use: hazard present with stall = 1 -> IDEX holds the load, bubble_count unchanged. Release stall -> bubble inserted, bubble_count = 1.
- Saturation: CNT_W = 2, apply 5 consecutive flushes -> flush_count = 3 and stays at 3.
